// File: rtl/clock_lock_manager_if.sv
// clock_lock_manager_if: PLL lock input, counter clear and reset/status outputs of the lock manager
interface clock_lock_manager_if #(
  parameter int NUM_RST_p    = 3,
  parameter int LOSS_CNT_W_p = 8
);
  logic                    pll_locked_i;
  logic                    clear_count_i;
  logic                    clk_pix_locked_o;
  logic [NUM_RST_p-1:0]    rst_o;
  logic                    ready_o;
  logic [LOSS_CNT_W_p-1:0] lock_loss_count_o;
  logic [1:0]              state_o;
  modport master (
    output pll_locked_i, clear_count_i,
    input  clk_pix_locked_o, rst_o, ready_o, lock_loss_count_o, state_o
  );
  modport slave (
    input  pll_locked_i, clear_count_i,
    output clk_pix_locked_o, rst_o, ready_o, lock_loss_count_o, state_o
  );
endinterface

// File: rtl/clock_lock_manager.sv
// clock_lock_manager: qualifies PLL lock, sequences staggered domain resets, counts lock losses
module clock_lock_manager #(
  parameter int SYNC_STAGES_p   = 2,
  parameter int GLITCH_FILTER_p = 4,
  parameter int HOLD_CYCLES_p   = 1024,
  parameter int NUM_RST_p       = 3,
  parameter int STAGGER_p       = 16,
  parameter int LOSS_CNT_W_p    = 8
) (
  input logic                 clk_pix_i,
  input logic                 reset_i,
  clock_lock_manager_if.slave bus
);
  localparam logic [1:0] WAIT    = 2'd0;
  localparam logic [1:0] HOLD    = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;
  localparam logic [1:0] RUN     = 2'd3;
  // one shared counter serves the filter, hold and stagger phases, so size it for the largest
  localparam int M1    = GLITCH_FILTER_p > HOLD_CYCLES_p ? GLITCH_FILTER_p : HOLD_CYCLES_p;
  localparam int MAX_C = M1 > STAGGER_p ? M1 : STAGGER_p;
  localparam int CNT_W = $clog2(MAX_C + 1);
  localparam logic [CNT_W-1:0] FILT_END = CNT_W'(GLITCH_FILTER_p - 1);
  localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(HOLD_CYCLES_p - 1);
  localparam logic [CNT_W-1:0] STAG_END = CNT_W'(STAGGER_p - 1);
  logic [SYNC_STAGES_p-1:0] sync_q;
  logic [1:0]               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [NUM_RST_p-1:0]     rst_q, rst_d, shifted;
  logic [LOSS_CNT_W_p-1:0]  loss_q, loss_d;
  logic                     lock, inc;
  assign lock    = sync_q[SYNC_STAGES_p-1];
  // resets are held as a contiguous run of ones at the top; shifting left releases the next lowest bit
  assign shifted = rst_q << 1;
  assign inc     = !lock && state_q == RUN;
  // lock synchroniser for the asynchronous PLL LOCK
  always_ff @(posedge clk_pix_i or posedge reset_i)
    if (reset_i) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES_p-2:0], bus.pll_locked_i};
  // next-state logic: any lock drop outside WAIT returns to WAIT with all resets asserted
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    if (!lock) begin
      state_d = WAIT;
      cnt_d   = '0;
      rst_d   = '1;
    end else begin
      case (state_q)
        WAIT: begin
          state_d = cnt_q == FILT_END ? HOLD : WAIT;
          cnt_d   = cnt_q == FILT_END ? '0 : cnt_q + CNT_W'(1);
        end
        HOLD: begin
          state_d = cnt_q != HOLD_END ? HOLD : shifted == '0 ? RUN : RELEASE;
          cnt_d   = cnt_q == HOLD_END ? '0 : cnt_q + CNT_W'(1);
          rst_d   = cnt_q == HOLD_END ? shifted : rst_q;
        end
        RELEASE: begin
          state_d = cnt_q == STAG_END && shifted == '0 ? RUN : RELEASE;
          cnt_d   = cnt_q == STAG_END ? '0 : cnt_q + CNT_W'(1);
          rst_d   = cnt_q == STAG_END ? shifted : rst_q;
        end
        default: ;
      endcase
    end
  end
  // saturating lock-loss counter; a clear coincident with a loss leaves one
  always_comb begin
    loss_d = bus.clear_count_i ? LOSS_CNT_W_p'(inc) :
             inc && loss_q != '1 ? loss_q + LOSS_CNT_W_p'(1) : loss_q;
  end
  // FSM, counter and reset-output registers
  always_ff @(posedge clk_pix_i or posedge reset_i)
    if (reset_i) begin
      state_q <= WAIT;
      cnt_q   <= '0;
      rst_q   <= '1;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      loss_q  <= loss_d;
    end
  assign bus.clk_pix_locked_o  = lock;
  assign bus.rst_o             = rst_q;
  assign bus.ready_o           = ~|rst_q;
  assign bus.lock_loss_count_o = loss_q;
  assign bus.state_o           = state_q;
endmodule

// File: tb/tb_clock_lock_manager.sv
// tb_clock_lock_manager: directed checks of lock filtering, reset staggering and loss counting
module tb_clock_lock_manager;
  logic clk_pix_i = 1'b0;
  logic reset_i;
  int n_checks = 0;
  int n_fail   = 0;
  clock_lock_manager_if #(.NUM_RST_p(3), .LOSS_CNT_W_p(8)) bus ();
  clock_lock_manager #(
    .SYNC_STAGES_p(2), .GLITCH_FILTER_p(4), .HOLD_CYCLES_p(8),
    .NUM_RST_p(3), .STAGGER_p(2), .LOSS_CNT_W_p(8)
  ) dut (
    .clk_pix_i(clk_pix_i),
    .reset_i  (reset_i),
    .bus      (bus)
  );
  always #5 clk_pix_i = ~clk_pix_i;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_pix_i);
      #1;
    end
  endtask
  task automatic check_outs(input string tag, input int r, input int rdy, input int st);
    check({tag, "_rst"}, 32'(bus.rst_o), r);
    check({tag, "_ready"}, 32'(bus.ready_o), rdy);
    check({tag, "_state"}, 32'(bus.state_o), st);
  endtask
  initial begin
    reset_i = 1'b1;
    bus.pll_locked_i  = 1'b0;
    bus.clear_count_i = 1'b0;
    tick(3);
    check_outs("reset", 7, 0, 0);
    check("reset_count", 32'(bus.lock_loss_count_o), 0);
    check("reset_locked", 32'(bus.clk_pix_locked_o), 0);
    reset_i = 1'b0;
    tick(2);
    check_outs("idle", 7, 0, 0);
    // cold lock
    bus.pll_locked_i = 1'b1;
    tick(1);  check("cold_locked_e1", 32'(bus.clk_pix_locked_o), 0);
    tick(1);  check("cold_locked_e2", 32'(bus.clk_pix_locked_o), 1);
    tick(3);  check("cold_state_e5", 32'(bus.state_o), 0);
    tick(1);  check("cold_state_e6", 32'(bus.state_o), 1);
    tick(7);  check_outs("cold_e13", 7, 0, 1);
    tick(1);  check_outs("cold_e14", 6, 0, 2);
    tick(1);  check_outs("cold_e15", 6, 0, 2);
    tick(1);  check_outs("cold_e16", 4, 0, 2);
    tick(1);  check_outs("cold_e17", 4, 0, 2);
    tick(1);  check_outs("cold_e18", 0, 1, 3);
    tick(5);  check_outs("cold_run", 0, 1, 3);
    // lock loss in RUN, then re-lock
    bus.pll_locked_i = 1'b0;
    tick(2);  check_outs("loss_e2", 0, 1, 3);
    tick(1);  check_outs("loss_e3", 7, 0, 0);
    check("loss_count", 32'(bus.lock_loss_count_o), 1);
    bus.pll_locked_i = 1'b1;
    tick(13); check_outs("relock_e13", 7, 0, 1);
    tick(1);  check_outs("relock_e14", 6, 0, 2);
    tick(2);  check_outs("relock_e16", 4, 0, 2);
    tick(2);  check_outs("relock_e18", 0, 1, 3);
    check("relock_count", 32'(bus.lock_loss_count_o), 1);
    // asynchronous reset in RUN clears the counter without a clock edge
    #3 reset_i = 1'b1;
    #1;
    check_outs("arst_run", 7, 0, 0);
    check("arst_run_count", 32'(bus.lock_loss_count_o), 0);
    bus.pll_locked_i = 1'b0;
    tick(2);
    reset_i = 1'b0;
    // loss during RELEASE does not count
    bus.pll_locked_i = 1'b1;
    tick(14); check_outs("rel_loss_pre", 6, 0, 2);
    bus.pll_locked_i = 1'b0;
    tick(3);  check_outs("rel_loss", 7, 0, 0);
    check("rel_loss_count", 32'(bus.lock_loss_count_o), 0);
    // glitch of three cycles is rejected
    bus.pll_locked_i = 1'b1;
    tick(3);
    bus.pll_locked_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check_outs($sformatf("glitch_%0d", i), 7, 0, 0);
    end
    bus.pll_locked_i = 1'b1;
    tick(13); check_outs("post_glitch_e13", 7, 0, 1);
    tick(1);  check_outs("post_glitch_e14", 6, 0, 2);
    tick(2);  check_outs("post_glitch_e16", 4, 0, 2);
    tick(2);  check_outs("post_glitch_e18", 0, 1, 3);
    // asynchronous reset mid-RELEASE
    bus.pll_locked_i = 1'b0;
    tick(3);
    check("pre_arst_count", 32'(bus.lock_loss_count_o), 1);
    bus.pll_locked_i = 1'b1;
    tick(15); check_outs("arst_rel_pre", 6, 0, 2);
    #3 reset_i = 1'b1;
    #1;
    check_outs("arst_rel", 7, 0, 0);
    check("arst_rel_count", 32'(bus.lock_loss_count_o), 0);
    check("arst_rel_locked", 32'(bus.clk_pix_locked_o), 0);
    bus.pll_locked_i = 1'b0;
    tick(2);
    reset_i = 1'b0;
    tick(1);
    // saturation
    for (int i = 0; i < 300; i++) begin
      bus.pll_locked_i = 1'b1;
      tick(18);
      bus.pll_locked_i = 1'b0;
      tick(3);
      if (i == 254) check("sat_255", 32'(bus.lock_loss_count_o), 255);
    end
    check("sat_300", 32'(bus.lock_loss_count_o), 255);
    // clear coincident with a loss, then clear alone
    bus.pll_locked_i = 1'b1;
    tick(18); check("clr_run", 32'(bus.state_o), 3);
    bus.pll_locked_i = 1'b0;
    tick(2);
    bus.clear_count_i = 1'b1;
    tick(1);
    bus.clear_count_i = 1'b0;
    check("clr_with_loss", 32'(bus.lock_loss_count_o), 1);
    bus.clear_count_i = 1'b1;
    tick(1);
    bus.clear_count_i = 1'b0;
    check("clr_alone", 32'(bus.lock_loss_count_o), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/clock_lock_manager.md
Name: clock_lock_manager

Overview:
- Parametrised lock-qualification and reset-sequencing block on the pixel-clock domain, downstream of the iCE40 PLL wrapper.
- Synchronises the raw PLL LOCK and filters lock glitches.
- Holds, then releases, a configurable number of per-domain resets in staggered order.
- Counts lock-loss events for debug and status readback.

Parameters:
- SYNC_STAGES_p, 2, synchroniser depth for pll_locked_i (legal >= 2).
- GLITCH_FILTER_p, 4, consecutive synced-high cycles required to accept lock (>= 1).
- HOLD_CYCLES_p, 1024, cycles all resets stay asserted after lock is accepted (>= 1).
- NUM_RST_p, 3, number of reset outputs (>= 1).
- STAGGER_p, 16, cycles between successive reset releases (>= 1).
- LOSS_CNT_W_p, 8, width of the lock-loss counter (>= 1).

Ports:
- clk_pix_i  in  1  pixel clock; all state is posedge.
- reset_i  in  1  asynchronous, active-high reset.
- pll_locked_i  in  1  raw PLL LOCK, asynchronous to clk_pix_i.
- clear_count_i  in  1  synchronous clear of lock_loss_count_o.
- clk_pix_locked_o  out  1  synchronised lock; the final synchroniser stage.
- rst_o  out  NUM_RST_p  active-high domain resets; bit 0 is released first.
- ready_o  out  1  high when every rst_o bit is released.
- lock_loss_count_o  out  LOSS_CNT_W_p  saturating count of lock losses seen in RUN.
- state_o  out  2  FSM state: WAIT=0, HOLD=1, RELEASE=2, RUN=3.

Behaviour:

Reset (reset_i high, asynchronous):
- All synchroniser stages = 0.
- clk_pix_locked_o = 0, rst_o = all ones, ready_o = 0.
- lock_loss_count_o = 0, state = WAIT, all internal counters = 0.
- The same values apply when reset_i asserts mid-operation in any state.

Synchroniser:
- pll_locked_i passes through SYNC_STAGES_p flops.
- A level change sampled at edge 1 appears on clk_pix_locked_o after edge SYNC_STAGES_p.
- The FSM uses clk_pix_locked_o (L below) only.

WAIT:
- rst_o all ones.
- Filter counter increments each cycle L=1 and clears on L=0.
- When L=1 and the counter = GLITCH_FILTER_p-1, go to HOLD.
- Result: lock high for fewer than GLITCH_FILTER_p consecutive cycles never leaves WAIT.

HOLD:
- Counts HOLD_CYCLES_p cycles, then goes to RELEASE.
- On entering RELEASE, rst_o[0] deasserts.

RELEASE:
- rst_o[i] deasserts i*STAGGER_p cycles after rst_o[0].
- The edge that deasserts rst_o[NUM_RST_p-1] also sets ready_o=1 and state RUN.
- If NUM_RST_p=1, RELEASE lasts zero cycles: rst_o[0] deasserts, ready_o=1 and state=RUN all on the same edge.

Lock drop:
- L=0 in HOLD, RELEASE or RUN sends the FSM to WAIT on the next edge.
- That edge sets rst_o all ones, ready_o=0 and clears all counters.
- Only a drop from RUN increments lock_loss_count_o.

Counter:
- lock_loss_count_o saturates at 2^LOSS_CNT_W_p-1.
- clear_count_i zeroes it.
- Clear and increment on the same edge: result is 1.

Timing: first edge that samples pll_locked_i high is edge 1.
- rst_o[0] deasserts after edge SYNC_STAGES_p+GLITCH_FILTER_p+HOLD_CYCLES_p.
- Lock-drop response: rst_o reasserts after edge SYNC_STAGES_p+1.

Other rules:
- rst_o bits never deassert out of order.
- A released bit never reasserts except on a lock drop or reset_i.

Test Plan:
All scenarios use SYNC=2, FILTER=4, HOLD=8, STAGGER=2, NUM_RST=3, W=8.
1. Cold lock: reset_i pulse, then pll_locked_i=1 from edge 1 -> clk_pix_locked_o=1 after edge 2; rst_o=3'b110 after edge 14, 3'b100 after edge 16, 3'b000 and ready_o=1 (state_o=3) after edge 18.
2. Glitch reject: pll_locked_i high for 3 cycles, low, then high steadily -> state_o stays 0 and rst_o=3'b111 through the glitch; after the rise, the sequence completes 14/16/18 edges after the final rise.
3. Lock loss in RUN: drop pll_locked_i at edge k -> rst_o=3'b111, ready_o=0, state_o=0 after edge k+3; lock_loss_count_o=1; re-lock repeats scenario 1 timing.
4. Loss during RELEASE (rst_o=3'b110) -> rst_o returns to 3'b111; lock_loss_count_o unchanged (0).
5. Saturation/clear: 300 lock losses from RUN -> count=255; clear_count_i coincident with a loss -> count=1; clear alone -> 0.
6. Async reset mid-RELEASE: reset_i asserted between edges -> rst_o=3'b111, count=0, state_o=0 immediately, without waiting for a clock edge.
